// File: rtl/ex_stage_mdu.sv
// RV32I/RV32M execute stage with valid/ready handshake, single-cycle multiply
// and an optional iterative divider enabled by the EX_DIV_EN macro.
module ex_stage_mdu #(
  parameter int XLEN      = 32,
  parameter int PC_WIDTH  = 16,
  parameter int DIV_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic [6:0]          opcode_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     rs1_data_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  input  logic                rd_we_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                flush_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                rd_we,
  output logic [4:0]          rd_addr,
  output logic [XLEN-1:0]     rd_data,
  output logic                busy
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  if ((2 ** DIV_CNT_W) <= XLEN) begin : g_cnt_check
    $error("DIV_CNT_W too small for XLEN");
  end

  logic            out_valid_r, rd_we_r;
  logic [4:0]      rd_addr_r;
  logic [XLEN-1:0] rd_data_r;

  logic            is_op_s, is_opimm_s, is_m_s, is_div_s, accept_s, div_start_s;
  logic [XLEN-1:0] opb_s, alu_s, mul_s, res_s, div_fast_s;
  logic [SH_W-1:0] shamt_s;
  logic            mul_a_sgn_s, mul_b_sgn_s;
  logic [2*XLEN-1:0] prod_s;
  logic            load_s, load_we_s;
  logic [4:0]      load_addr_s;
  logic [XLEN-1:0] load_data_s;

  assign is_op_s    = (opcode_i == OPC_OP);
  assign is_opimm_s = (opcode_i == OPC_OPIMM);
  assign is_m_s     = is_op_s && (funct7_i == F7_MULDIV);
  assign is_div_s   = is_m_s && funct3_i[2];
  assign opb_s      = is_op_s ? rs2_data_i : imm_i;
  assign shamt_s    = opb_s[SH_W-1:0];
  assign accept_s   = in_valid && in_ready && !flush_i;

  // Integer ALU for OP / OP-IMM
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (funct3_i)
      3'b000: begin
        if (is_op_s && funct7_i[5]) alu_s = rs1_data_i - opb_s;
        else                        alu_s = rs1_data_i + opb_s;
      end
      3'b001: alu_s = rs1_data_i << shamt_s;
      3'b010: alu_s = {{(XLEN-1){1'b0}}, ($signed(rs1_data_i) < $signed(opb_s))};
      3'b011: alu_s = {{(XLEN-1){1'b0}}, (rs1_data_i < opb_s)};
      3'b100: alu_s = rs1_data_i ^ opb_s;
      3'b101: begin
        if (funct7_i[5]) alu_s = $unsigned($signed(rs1_data_i) >>> shamt_s);
        else             alu_s = rs1_data_i >> shamt_s;
      end
      3'b110: alu_s = rs1_data_i | opb_s;
      3'b111: alu_s = rs1_data_i & opb_s;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Operands extended to 2*XLEN so one unsigned multiply covers all MUL variants
  assign mul_a_sgn_s = (funct3_i[1:0] != 2'b11) && rs1_data_i[XLEN-1];
  assign mul_b_sgn_s = (funct3_i[1:0] == 2'b01) && rs2_data_i[XLEN-1];
  assign prod_s = {{XLEN{mul_a_sgn_s}}, rs1_data_i} * {{XLEN{mul_b_sgn_s}}, rs2_data_i};
  assign mul_s  = (funct3_i[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  // Single-cycle result select
  always_comb begin
    res_s = {XLEN{1'b0}};
    if (opcode_i == OPC_LUI) begin
      res_s = imm_i;
    end else if (opcode_i == OPC_AUIPC) begin
      res_s = {{(XLEN-PC_WIDTH){1'b0}}, pc_i} + imm_i;
    end else if (is_m_s) begin
      res_s = funct3_i[2] ? div_fast_s : mul_s;
    end else if (is_op_s || is_opimm_s) begin
      res_s = alu_s;
    end else begin
      res_s = {XLEN{1'b0}};
    end
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(XLEN - 1);

  state_t               state_r, state_n;
  logic                 busy_r;
  logic [DIV_CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]      quo_r, rem_r, dvs_r;
  logic                 neg_q_r, neg_r_r, is_rem_r, div_we_r;
  logic [4:0]           div_addr_r;
  logic                 sgn_s, a_neg_s, b_neg_s, ovf_s, qbit_s;
  logic [XLEN-1:0]      mag_a_s, mag_b_s, rem_n_s, div_out_s;
  logic [XLEN:0]        shifted_s, trial_s;

  assign sgn_s     = !funct3_i[0];
  assign a_neg_s   = sgn_s && rs1_data_i[XLEN-1];
  assign b_neg_s   = sgn_s && rs2_data_i[XLEN-1];
  assign mag_a_s   = a_neg_s ? ({XLEN{1'b0}} - rs1_data_i) : rs1_data_i;
  assign mag_b_s   = b_neg_s ? ({XLEN{1'b0}} - rs2_data_i) : rs2_data_i;
  assign ovf_s     = sgn_s && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == {XLEN{1'b1}});

  // Divide-by-zero and overflow resolve immediately; everything else iterates
  always_comb begin
    div_fast_s  = {XLEN{1'b0}};
    div_start_s = 1'b0;
    if (rs2_data_i == {XLEN{1'b0}}) begin
      div_fast_s = funct3_i[1] ? rs1_data_i : {XLEN{1'b1}};
    end else if (ovf_s) begin
      div_fast_s = funct3_i[1] ? {XLEN{1'b0}} : rs1_data_i;
    end else begin
      div_start_s = is_div_s;
    end
  end

  assign shifted_s = {rem_r, quo_r[XLEN-1]};
  assign trial_s   = shifted_s - {1'b0, dvs_r};
  assign qbit_s    = !trial_s[XLEN];
  assign rem_n_s   = qbit_s ? trial_s[XLEN-1:0] : shifted_s[XLEN-1:0];
  assign div_out_s = is_rem_r ? (neg_r_r ? ({XLEN{1'b0}} - rem_r) : rem_r)
                              : (neg_q_r ? ({XLEN{1'b0}} - quo_r) : quo_r);

  // Divider next-state
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && div_start_s) state_n = DIV;
        else                         state_n = IDLE;
      end
      DIV: begin
        if (cnt_r == DIV_LAST) state_n = DONE;
        else                   state_n = DIV;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
    else         state_n = state_n;
  end

  // Divider state and busy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  // Divider datapath: operand latch on start, one restoring step per DIV cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {DIV_CNT_W{1'b0}};
      quo_r <= {XLEN{1'b0}};
      rem_r <= {XLEN{1'b0}};
      dvs_r <= {XLEN{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      is_rem_r <= 1'b0;
      div_we_r <= 1'b0;
      div_addr_r <= 5'd0;
    end else if (accept_s && div_start_s) begin
      cnt_r <= {DIV_CNT_W{1'b0}};
      quo_r <= mag_a_s;
      rem_r <= {XLEN{1'b0}};
      dvs_r <= mag_b_s;
      neg_q_r <= a_neg_s ^ b_neg_s;
      neg_r_r <= a_neg_s;
      is_rem_r <= funct3_i[1];
      div_we_r <= rd_we_i;
      div_addr_r <= rd_addr_i;
    end else if (state_r == DIV) begin
      cnt_r <= cnt_r + DIV_CNT_W'(1);
      quo_r <= {quo_r[XLEN-2:0], qbit_s};
      rem_r <= rem_n_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign busy     = busy_r;

  // Output-register load source
  always_comb begin
    load_s      = accept_s && !div_start_s;
    load_we_s   = rd_we_i;
    load_addr_s = rd_addr_i;
    load_data_s = res_s;
    if (state_r == DONE) begin
      load_s      = 1'b1;
      load_we_s   = div_we_r;
      load_addr_s = div_addr_r;
      load_data_s = div_out_s;
    end else begin
      load_s      = accept_s && !div_start_s;
    end
  end
`else
  assign div_fast_s  = {XLEN{1'b0}};
  assign div_start_s = 1'b0;
  assign in_ready    = !out_valid_r || out_ready;
  assign busy        = 1'b0;
  assign load_s      = accept_s;
  assign load_we_s   = rd_we_i;
  assign load_addr_s = rd_addr_i;
  assign load_data_s = res_s;
`endif

  // Write-back register: flush first, then new result, then drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      rd_we_r     <= 1'b0;
      rd_addr_r   <= 5'd0;
      rd_data_r   <= {XLEN{1'b0}};
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      rd_we_r     <= load_we_s;
      rd_addr_r   <= load_addr_s;
      rd_data_r   <= load_data_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign rd_we     = rd_we_r;
  assign rd_addr   = rd_addr_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed self-checking bench for ex_stage_mdu; divider sequences follow EX_DIV_EN.
module tb_ex_stage_mdu;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] F7_ZERO  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] F7_M     = 7'b0000001;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] pc_i = 16'd0;
  logic [6:0]  opcode_i = 7'd0, funct7_i = 7'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] imm_i = 32'd0, rs1_data_i = 32'd0, rs2_data_i = 32'd0;
  logic        rd_we_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        flush_i = 1'b0, out_valid, out_ready = 1'b1, rd_we, busy;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;
  int n;
  logic saw;

  ex_stage_mdu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i),
    .opcode_i(opcode_i), .funct7_i(funct7_i), .funct3_i(funct3_i), .imm_i(imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_we_i(rd_we_i),
    .rd_addr_i(rd_addr_i), .flush_i(flush_i), .out_valid(out_valid),
    .out_ready(out_ready), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic we, input logic [4:0] ad);
    in_valid = 1'b1; opcode_i = op; funct7_i = f7; funct3_i = f3;
    rs1_data_i = a; rs2_data_i = b; imm_i = im; rd_we_i = we; rd_addr_i = ad;
  endtask

  // Issue for exactly one accepting edge, then drop in_valid
  task automatic run1(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    issue(op, f7, f3, a, b, im, 1'b1, 5'd3);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd_we", {31'd0, rd_we}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    issue(OP_IMM, F7_ZERO, 3'b000, 32'h7FFF_FFFF, 32'd0, 32'd1, 1'b1, 5'd5);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_data", rd_data, 32'h8000_0000);
    chk("addi_we", {31'd0, rd_we}, 32'd1);
    chk("addi_addr", {27'd0, rd_addr}, 32'd5);

    run1(OP_IMM, F7_ALT, 3'b101, 32'h8000_0000, 32'd0, 32'd4);
    chk("srai", rd_data, 32'hF800_0000);
    run1(OP_IMM, F7_ZERO, 3'b101, 32'h8000_0000, 32'd0, 32'd4);
    chk("srli", rd_data, 32'h0800_0000);
    run1(OP_REG, F7_ALT, 3'b000, 32'd5, 32'd7, 32'd0);
    chk("sub", rd_data, 32'hFFFF_FFFE);
    run1(OP_REG, F7_ALT, 3'b101, 32'h8000_00F0, 32'd36, 32'd0);
    chk("sra_low5", rd_data, 32'hF800_000F);
    run1(OP_REG, F7_ZERO, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("slt", rd_data, 32'd1);
    run1(OP_REG, F7_ZERO, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0);
    chk("sltu", rd_data, 32'd0);
    run1(OP_LUI, F7_ZERO, 3'b000, 32'd0, 32'd0, 32'h1234_5000);
    chk("lui", rd_data, 32'h1234_5000);
    pc_i = 16'hF000;
    run1(OP_AUIPC, F7_ZERO, 3'b000, 32'd0, 32'd0, 32'h0000_0010);
    chk("auipc", rd_data, 32'h0000_F010);

    run1(OP_REG, F7_M, 3'b000, 32'd3, 32'hFFFF_FFFB, 32'd0);
    chk("mul", rd_data, 32'hFFFF_FFF1);
    run1(OP_REG, F7_M, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    chk("mulh", rd_data, 32'h0000_0000);
    run1(OP_REG, F7_M, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    chk("mulhu", rd_data, 32'hFFFF_FFFE);
    run1(OP_REG, F7_M, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    chk("mulhsu", rd_data, 32'hFFFF_FFFF);

    issue(7'b1111111, F7_ZERO, 3'b000, 32'd9, 32'd9, 32'd9, 1'b1, 5'd12);
    tick();
    in_valid = 1'b0;
    chk("unknown_data", rd_data, 32'd0);
    chk("unknown_we", {31'd0, rd_we}, 32'd1);
    chk("unknown_addr", {27'd0, rd_addr}, 32'd12);
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef EX_DIV_EN
    run1(OP_REG, F7_M, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0);
    for (int i = 0; i < 33; i++) begin
      chk("div_busy", {31'd0, busy}, 32'd1);
      chk("div_stall", {31'd0, in_ready}, 32'd0);
      chk("div_early", {31'd0, out_valid}, 32'd0);
      tick();
    end
    chk("div_valid", {31'd0, out_valid}, 32'd1);
    chk("div_data", rd_data, 32'hFFFF_FFFD);
    chk("div_busy_done", {31'd0, busy}, 32'd0);
    chk("div_ready_done", {31'd0, in_ready}, 32'd1);

    run1(OP_REG, F7_M, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'd0);
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk("rem_latency", 32'(n), 32'd33);
    chk("rem_data", rd_data, 32'hFFFF_FFFF);

    run1(OP_REG, F7_M, 3'b101, 32'hFFFF_FFFF, 32'd3, 32'd0);
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk("divu_latency", 32'(n), 32'd33);
    chk("divu_data", rd_data, 32'h5555_5555);

    run1(OP_REG, F7_M, 3'b101, 32'd123, 32'd0, 32'd0);
    chk("divu0_valid", {31'd0, out_valid}, 32'd1);
    chk("divu0_data", rd_data, 32'hFFFF_FFFF);
    chk("divu0_busy", {31'd0, busy}, 32'd0);
    run1(OP_REG, F7_M, 3'b111, 32'd10, 32'd0, 32'd0);
    chk("remu0_data", rd_data, 32'd10);
    run1(OP_REG, F7_M, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    chk("ovf_div_valid", {31'd0, out_valid}, 32'd1);
    chk("ovf_div_data", rd_data, 32'h8000_0000);
    run1(OP_REG, F7_M, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    chk("ovf_rem_data", rd_data, 32'd0);
    tick();

    run1(OP_REG, F7_M, 3'b100, 32'd100, 32'd7, 32'd0);
    repeat (5) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    saw = 1'b0;
    repeat (40) begin tick(); if (out_valid) saw = 1'b1; end
    chk("flush_no_result", {31'd0, saw}, 32'd0);

    run1(OP_REG, F7_M, 3'b100, 32'd100, 32'd7, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rstdiv_busy", {31'd0, busy}, 32'd0);
    chk("rstdiv_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstdiv_ready", {31'd0, in_ready}, 32'd1);
`else
    run1(OP_REG, F7_M, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'd0);
    chk("nodiv_valid", {31'd0, out_valid}, 32'd1);
    chk("nodiv_data", rd_data, 32'd0);
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    chk("nodiv_ready", {31'd0, in_ready}, 32'd1);
    run1(OP_REG, F7_M, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'd0);
    chk("norem_data", rd_data, 32'd0);
    run1(OP_REG, F7_M, 3'b101, 32'd123, 32'd0, 32'd0);
    chk("nodivu0_data", rd_data, 32'd0);
    tick();
`endif

    out_ready = 1'b0;
    issue(OP_REG, F7_ZERO, 3'b000, 32'd10, 32'd20, 32'd0, 1'b1, 5'd7);
    tick();
    chk("bp_load_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_load_data", rd_data, 32'd30);
    issue(OP_REG, F7_ZERO, 3'b100, 32'h0000_00F0, 32'h0000_00FF, 32'd0, 1'b1, 5'd8);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", rd_data, 32'd30);
      chk("bp_hold_addr", {27'd0, rd_addr}, 32'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
    chk("b2b_data1", rd_data, 32'h0000_000F);
    chk("b2b_addr1", {27'd0, rd_addr}, 32'd8);
    issue(OP_REG, F7_ZERO, 3'b110, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b1, 5'd9);
    tick();
    chk("b2b_data2", rd_data, 32'h0000_00FF);
    chk("b2b_addr2", {27'd0, rd_addr}, 32'd9);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    run1(OP_REG, F7_ZERO, 3'b111, 32'h0000_0F0F, 32'h0000_00FF, 32'd0);
    chk("held_and", rd_data, 32'h0000_000F);
    out_ready = 1'b1;
    issue(OP_REG, F7_ZERO, 3'b000, 32'd1, 32'd1, 32'd0, 1'b1, 5'd4);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_dropped", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
